// File: rtl/icache_direct_param.sv
// icache_direct_param: direct-mapped instruction cache with multi-word lines, burst fill and whole-cache invalidate.
// Define ICACHE_STATS_EN to add saturating hit_count/miss_count outputs.
module icache_direct_param #(
   parameter int WORD_W = 32,
   parameter int SETS = 16,
   parameter int WORDS_PER_BLOCK = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   input  logic              inv,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
`ifdef ICACHE_STATS_EN
   ,
   output logic [31:0]       hit_count,
   output logic [31:0]       miss_count
`endif
);
   localparam int OFF_B = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_B = $clog2(SETS);
   localparam int CNT_W = OFF_B > 0 ? OFF_B : 1;
   localparam int LINE_B = IDX_B + OFF_B;
   localparam int TAG_LSB = 2 + LINE_B;
   localparam int TAG_W = WORD_W - TAG_LSB;
   typedef enum logic {IDLE, FILL} state_t;
   state_t state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_B-1:0] fill_idx_q, fill_idx_d;
   logic [TAG_W-1:0] fill_tag_q, fill_tag_d;
   logic [SETS-1:0] valid_q, valid_d;
   logic [TAG_W-1:0] tag_q [SETS];
   logic [WORD_W-1:0] data_q [SETS*WORDS_PER_BLOCK];
   logic [IDX_B-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic beat, last, miss;
   always_comb begin
      req_tag = imemaddr[WORD_W-1:TAG_LSB];
      req_idx = IDX_B'(imemaddr >> (2 + OFF_B));
      ihit = imemREN && state_q == IDLE && valid_q[req_idx] && tag_q[req_idx] == req_tag;
      imemload = ihit ? data_q[LINE_B'(imemaddr >> 2)] : '0;
      iREN = state_q == FILL;
      iaddr = iREN ? (WORD_W'(fill_tag_q) << TAG_LSB) | (WORD_W'(fill_idx_q) << (2 + OFF_B))
                     | (WORD_W'(cnt_q) << 2) : '0;
      // a beat landing in the same cycle as inv is dropped
      beat = iREN && !iwait && !inv;
      last = cnt_q == CNT_W'(WORDS_PER_BLOCK - 1);
      miss = imemREN && state_q == IDLE && !ihit;
   end
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      fill_idx_d = fill_idx_q;
      fill_tag_d = fill_tag_q;
      valid_d = inv ? '0 : valid_q;
      if (miss) begin
         state_d = FILL;
         cnt_d = '0;
         fill_idx_d = req_idx;
         fill_tag_d = req_tag;
      end
      if (iREN && inv) begin
         state_d = IDLE;
         cnt_d = '0;
      end else if (beat) begin
         valid_d[fill_idx_q] = last;
         cnt_d = last ? '0 : cnt_q + 1'b1;
         state_d = last ? IDLE : FILL;
      end
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
         cnt_q <= '0;
         fill_idx_q <= '0;
         fill_tag_q <= '0;
         valid_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         fill_idx_q <= fill_idx_d;
         fill_tag_q <= fill_tag_d;
         valid_q <= valid_d;
      end
   end
   // line storage carries no reset; the valid bits guard it
   always_ff @(posedge CLK) begin
      if (beat) data_q[LINE_B'(iaddr >> 2)] <= iload;
      if (beat && last) tag_q[fill_idx_q] <= fill_tag_q;
   end
`ifdef ICACHE_STATS_EN
   logic [31:0] hit_cnt_q, hit_cnt_d, miss_cnt_q, miss_cnt_d;
   always_comb begin
      hit_cnt_d = (ihit && !(&hit_cnt_q)) ? hit_cnt_q + 32'd1 : hit_cnt_q;
      miss_cnt_d = (miss && !(&miss_cnt_q)) ? miss_cnt_q + 32'd1 : miss_cnt_q;
   end
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         hit_cnt_q <= '0;
         miss_cnt_q <= '0;
      end else begin
         hit_cnt_q <= hit_cnt_d;
         miss_cnt_q <= miss_cnt_d;
      end
   end
   assign hit_count = hit_cnt_q;
   assign miss_count = miss_cnt_q;
`endif
endmodule
